phy_rx_unstripe: RTL
====================

PHY_RX_UNSTRIPE -- requirements
Module: phy_rx_unstripe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning width of the serial byte and of each lane output.
REQ-002 The block SHALL have parameter GAP_FLUSH, default 1, meaning that 1 flushes a partial group on an input gap and 0 holds the partial group across gaps.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in  input  DATA_W  serial byte stream from the lane-interleaving transmitter.
REQ-006 The block SHALL have port valid_in  input  1  data_in qualifier, sampled each rising edge.
REQ-007 The block SHALL have ports data_out0, data_out1, data_out2, data_out3  output  DATA_W each  recovered lane bytes, registered.
REQ-008 The block SHALL have ports valid_out0, valid_out1, valid_out2, valid_out3  output  1 each  per-lane one-cycle emit strobes, registered.
REQ-009 The block SHALL have port err_partial  output  1  one-cycle strobe flagging an emitted partial group.

Function
REQ-010 The block SHALL de-interleave the stream in fixed lane order: first byte of a group to lane 0, then lanes 1, 2, 3.
REQ-011 The block SHALL implement two states: IDLE (lane pointer 0, no bytes held) and COLLECT (lane pointer 1..3, bytes held for lanes below the pointer).
REQ-012 In IDLE with valid_in=1, the block SHALL store data_in for lane 0, set pointer to 1, and enter COLLECT.
REQ-013 In IDLE with valid_in=0, the block SHALL stay in IDLE with no state change.
REQ-014 In COLLECT with valid_in=1 and pointer 1 or 2, the block SHALL store data_in for the pointed lane and increment the pointer.
REQ-015 In COLLECT with valid_in=1 and pointer 3, the block SHALL load data_out0..2 from held bytes and data_out3 from data_in on the same edge, assert all four valid_out for exactly one cycle, and return to IDLE.
REQ-016 Latency SHALL be: first byte of a group sampled at edge N, its full group visible on outputs after edge N+3.
REQ-017 Back-to-back groups with valid_in continuously high SHALL produce one four-lane emit every 4 cycles with no dropped or stalled bytes.
REQ-018 In COLLECT with valid_in=0 and GAP_FLUSH=1, the block SHALL emit a partial group on that edge: lanes below the pointer load held bytes with valid_out=1; the remaining lanes keep previous data with valid_out=0; err_partial=1 for one cycle; state returns to IDLE.
REQ-019 In COLLECT with valid_in=0 and GAP_FLUSH=0, the block SHALL hold the pointer and the held bytes unchanged until valid_in returns.
REQ-020 data_outN SHALL hold its last emitted value until that lane is emitted again.
REQ-021 valid_outN and err_partial SHALL be low in every cycle other than the cycle following an emit edge.
REQ-022 The block SHALL perform no arithmetic on the data; the only arithmetic is the 2-bit lane pointer, which never wraps except via the return to IDLE.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force the state to IDLE, the pointer to 0, the held bytes to 0, data_out0..3 to 0, valid_out0..3 to 0, and err_partial to 0.
REQ-024 Reset asserted mid-group SHALL discard the partial group with no emit and no err_partial.
REQ-025 The first rising edge with reset=1 SHALL be treated as a normal IDLE cycle, and valid_in sampled on that edge SHALL be accepted.

Verification
REQ-026 Full group: bytes 0x11, 0x22, 0x33, 0x44 with valid on 4 consecutive edges -> data_out0..3 = 0x11/0x22/0x33/0x44, all valid_out=1 for one cycle after the 4th edge, err_partial=0.
REQ-027 Streaming: 12 consecutive valid bytes 0x00..0x0B -> three emits, 4 cycles apart; the last group is 0x08/0x09/0x0A/0x0B.
REQ-028 Gap flush (GAP_FLUSH=1): bytes 0xA0, 0xA1, then valid low -> valid_out0=valid_out1=1, valid_out2=valid_out3=0, data_out0=0xA0, data_out1=0xA1, data_out2/3 unchanged, err_partial=1 for one cycle.
REQ-029 Gap hold (GAP_FLUSH=0): bytes 0x01, 0x02, 3 idle cycles, then 0x03, 0x04 -> single full emit 0x01/0x02/0x03/0x04, err_partial never set.
REQ-030 Reset mid-group: bytes 0x55, 0x66, reset low for 1 cycle, then 0x77, 0x88, 0x99, 0xAA -> all outputs 0 during reset, next emit is 0x77/0x88/0x99/0xAA.
REQ-031 Loopback: lanes driven through the lane-interleaving transmitter into this block -> the four recovered lanes equal the transmitter inputs byte for byte.

Source files
------------

// File: rtl/phy_rx_unstripe.sv
// Receive-side lane un-striper: collects a serial byte stream into groups of four
// and emits them on four registered lane outputs, optionally flushing partial groups on gaps.
module phy_rx_unstripe #(
  parameter int DATA_W    = 8,
  parameter int GAP_FLUSH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic              err_partial,
  output logic [2:0]        dbg_state
);

  // Handshake: data_in is taken on every rising edge where valid_in=1; there is no
  // backpressure. valid_outN/err_partial are one-cycle strobes, data_outN hold between emits.
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic [DATA_W-1:0] r_hold [3];
  logic [DATA_W-1:0] w_hold_nxt [3];
  logic [DATA_W-1:0] r_dout [4];
  logic [DATA_W-1:0] w_dout_nxt [4];
  logic [3:0]        r_vout, w_vout_nxt;
  logic              r_err, w_err_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_dout_nxt  = r_dout;
    w_vout_nxt  = 4'b0000;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_hold_nxt[0] = data_in;
          w_ptr_nxt     = 2'd1;
          w_state_nxt   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (valid_in) begin
          if (r_ptr == 2'd3) begin
            for (int i = 0; i < 3; i++) w_dout_nxt[i] = r_hold[i];
            w_dout_nxt[3] = data_in;
            w_vout_nxt    = 4'b1111;
            w_ptr_nxt     = 2'd0;
            w_state_nxt   = S_IDLE;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (r_ptr == 2'(i)) w_hold_nxt[i] = data_in;
            end
            w_ptr_nxt = r_ptr + 2'd1;
          end
        end else if (GAP_FLUSH != 0) begin
          // Only lanes below the pointer hold real bytes; the rest keep their old data.
          for (int i = 0; i < 3; i++) begin
            if (2'(i) < r_ptr) begin
              w_dout_nxt[i] = r_hold[i];
              w_vout_nxt[i] = 1'b1;
            end
          end
          w_err_nxt   = 1'b1;
          w_ptr_nxt   = 2'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_ptr_nxt   = 2'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      for (int i = 0; i < 3; i++) r_hold[i] <= '0;
      for (int i = 0; i < 4; i++) r_dout[i] <= '0;
      r_vout  <= 4'b0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_dout  <= w_dout_nxt;
      r_vout  <= w_vout_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign data_out0   = r_dout[0];
  assign data_out1   = r_dout[1];
  assign data_out2   = r_dout[2];
  assign data_out3   = r_dout[3];
  assign valid_out0  = r_vout[0];
  assign valid_out1  = r_vout[1];
  assign valid_out2  = r_vout[2];
  assign valid_out3  = r_vout[3];
  assign err_partial = r_err;
  assign dbg_state   = {r_state, r_ptr};

endmodule
